flag_register_unit: RTL and testbench

- Condition-code register (Z, N, C) downstream of the execute-stage ALU.
- Captures the ALU flag outputs and feeds them back to the ALU flag inputs on the next cycle.
- Evaluates conditional jumps and consumes the tested flag when a jump is taken.
- Applies SETC/CLRC.
- Holds a small LIFO of saved flags so interrupt entry and RTI can nest.

---
 rtl/flag_register_unit.sv | 179 +++++++++++++++++
 tb/tb_flag_register_unit.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/flag_register_unit.sv
// flag_register_unit
// Z/N/C condition-code register sitting after the execute-stage ALU.
// - Captures ALU flags, applies SETC/CLRC, and clears the tested flag on a
//   taken conditional jump.
// - Keeps a small LIFO of saved flag triples for nested interrupt entry/RTI.
// Optional build macro: FLAG_REGISTER_BYPASS_EN. When it is defined, the flag
// outputs forward the combinational next-flag value whenever the ALU writes
// and the pipe is not stalled.
module flag_register_unit #(
    parameter int STACK_DEPTH = 4,
    parameter int DEPTH_W     = 3
) (
    input  logic               i_clk,
    input  logic               i_reset,
    input  logic               i_stall,
    input  logic               i_alu_we,
    input  logic               i_zero_flag,
    input  logic               i_negative_flag,
    input  logic               i_carry_flag,
    input  logic               i_setc,
    input  logic               i_clrc,
    input  logic [1:0]         i_jmp_cond,
    input  logic               i_save,
    input  logic               i_restore,
    output logic               o_zero_flag,
    output logic               o_negative_flag,
    output logic               o_carry_flag,
    output logic               o_jmp_taken,
    output logic [DEPTH_W-1:0] o_depth,
    output logic               o_full,
    output logic               o_empty,
    output logic               o_error
);

    // Stack is a packed shift register: the top entry always lives in [2:0].
    localparam int                 STACK_W   = 3 * STACK_DEPTH;
    localparam logic [DEPTH_W-1:0] DEPTH_MAX = DEPTH_W'(STACK_DEPTH);
    localparam logic [DEPTH_W-1:0] DEPTH_ONE = DEPTH_W'(1);

    // Jump condition encodings.
    localparam logic [1:0] JMP_NONE = 2'b00;
    localparam logic [1:0] JMP_Z    = 2'b01;
    localparam logic [1:0] JMP_N    = 2'b10;
    localparam logic [1:0] JMP_C    = 2'b11;

    // Flag triple layout is {Z, N, C}.
    logic [2:0]         flags_r;
    logic [STACK_W-1:0] stack_r;
    logic [DEPTH_W-1:0] depth_r;
    logic               error_r;

    logic               empty_s;
    logic               full_s;
    logic               jmp_taken_s;
    logic               pop_s;
    logic               push_s;
    logic               err_s;
    logic [2:0]         base_s;
    logic               carry_s;
    logic [2:0]         upd_s;
    logic [2:0]         next_s;

    // Returns the flag selected by a jump condition (0 for "no jump").
    function automatic logic tested_flag(input logic [2:0] f, input logic [1:0] cond);
        logic r;
        case (cond)
            JMP_Z:   r = f[2];
            JMP_N:   r = f[1];
            JMP_C:   r = f[0];
            JMP_NONE: r = 1'b0;
            default: r = 1'b0;
        endcase
        return r;
    endfunction

    // Clears the flag a taken jump consumes, leaving the other two bits alone.
    function automatic logic [2:0] clear_tested(input logic [2:0] f, input logic [1:0] cond);
        logic [2:0] r;
        case (cond)
            JMP_Z:   r = {1'b0, f[1], f[0]};
            JMP_N:   r = {f[2], 1'b0, f[0]};
            JMP_C:   r = {f[2], f[1], 1'b0};
            JMP_NONE: r = f;
            default: r = f;
        endcase
        return r;
    endfunction

    // Stack status, jump decision and stack-operation qualification.
    always_comb begin
        empty_s     = (depth_r == {DEPTH_W{1'b0}});
        full_s      = (depth_r == DEPTH_MAX);
        jmp_taken_s = tested_flag(flags_r, i_jmp_cond);
        pop_s       = !i_stall && i_restore && !empty_s;
        push_s      = !i_stall && i_save && !i_restore && !full_s;
        err_s       = (i_save && i_restore) || (i_restore && empty_s) || (i_save && full_s);
    end

    // Next-flag priority: a valid pop overrides everything; otherwise
    // ALU/held base, then SETC over CLRC, then the jump clear on top.
    always_comb begin
        if (i_alu_we) begin
            base_s = {i_zero_flag, i_negative_flag, i_carry_flag};
        end else begin
            base_s = flags_r;
        end
        if (i_setc) begin
            carry_s = 1'b1;
        end else if (i_clrc) begin
            carry_s = 1'b0;
        end else begin
            carry_s = base_s[0];
        end
        if (jmp_taken_s) begin
            upd_s = clear_tested({base_s[2:1], carry_s}, i_jmp_cond);
        end else begin
            upd_s = {base_s[2:1], carry_s};
        end
        if (pop_s) begin
            next_s = stack_r[2:0];
        end else begin
            next_s = upd_s;
        end
    end

    // Flag register; held while stalled.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            flags_r <= 3'b000;
        end else if (!i_stall) begin
            flags_r <= next_s;
        end else begin
            flags_r <= flags_r;
        end
    end

    // Save stack and depth count; push captures the pre-update flags.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            stack_r <= {STACK_W{1'b0}};
            depth_r <= {DEPTH_W{1'b0}};
        end else if (pop_s) begin
            stack_r <= stack_r >> 3'd3;
            depth_r <= depth_r - DEPTH_ONE;
        end else if (push_s) begin
            stack_r <= (stack_r << 3'd3) | STACK_W'(flags_r);
            depth_r <= depth_r + DEPTH_ONE;
        end else begin
            stack_r <= stack_r;
            depth_r <= depth_r;
        end
    end

    // Error pulse register; a stalled cycle drops any pending pulse so it
    // can never appear twice or late.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            error_r <= 1'b0;
        end else if (i_stall) begin
            error_r <= 1'b0;
        end else begin
            error_r <= err_s;
        end
    end

    assign o_jmp_taken = jmp_taken_s;
    assign o_depth     = depth_r;
    assign o_full      = full_s;
    assign o_empty     = empty_s;
    assign o_error     = error_r & ~i_stall;

`ifdef FLAG_REGISTER_BYPASS_EN
    assign {o_zero_flag, o_negative_flag, o_carry_flag} =
        (i_alu_we && !i_stall) ? next_s : flags_r;
`else
    assign {o_zero_flag, o_negative_flag, o_carry_flag} = flags_r;
`endif

endmodule

// File: tb/tb_flag_register_unit.sv
// Self-checking bench for flag_register_unit: directed scenarios plus a
// randomized run against a queue-based reference model.
module tb_flag_register_unit;

    localparam int SD = 4;
    localparam int DW = 3;

    logic          clk = 1'b0;
    logic          rst;
    logic          stall, alu_we, z_in, n_in, c_in, setc, clrc, save, restore;
    logic [1:0]    jc;
    logic          z_o, n_o, c_o, jt_o, full_o, empty_o, err_o;
    logic [DW-1:0] depth_o;

    int checks = 0;
    int errors = 0;

    // Reference model: flags indexed by jump code (1=Z, 2=N, 3=C).
    bit [1:3] m_fl;
    bit [1:3] m_q[$];
    bit       m_err;

    flag_register_unit #(.STACK_DEPTH(SD), .DEPTH_W(DW)) dut (
        .i_clk(clk), .i_reset(rst), .i_stall(stall), .i_alu_we(alu_we),
        .i_zero_flag(z_in), .i_negative_flag(n_in), .i_carry_flag(c_in),
        .i_setc(setc), .i_clrc(clrc), .i_jmp_cond(jc), .i_save(save),
        .i_restore(restore), .o_zero_flag(z_o), .o_negative_flag(n_o),
        .o_carry_flag(c_o), .o_jmp_taken(jt_o), .o_depth(depth_o),
        .o_full(full_o), .o_empty(empty_o), .o_error(err_o)
    );

    always #5 clk = ~clk;

    task automatic idle();
        stall = 0; alu_we = 0; z_in = 0; n_in = 0; c_in = 0;
        setc = 0; clrc = 0; jc = 2'b00; save = 0; restore = 0;
    endtask

    // act: 0 none, 1 push, 2 pop
    task automatic model_eval(output bit [1:3] nfl, output bit nerr, output int act);
        bit jt, full, empty;
        nfl = m_fl; nerr = 1'b0; act = 0;
        if (stall) return;
        empty = (m_q.size() == 0);
        full  = (m_q.size() == SD);
        jt    = (jc != 2'd0) ? m_fl[jc] : 1'b0;
        nerr  = (save && restore) || (restore && empty) || (save && full);
        if (restore && !empty) begin
            nfl = m_q[$];
            act = 2;
            return;
        end
        if (save && !restore && !full) act = 1;
        nfl = alu_we ? {z_in, n_in, c_in} : m_fl;
        if (setc) nfl[3] = 1'b1;
        else if (clrc) nfl[3] = 1'b0;
        if (jt) nfl[jc] = 1'b0;
    endtask

    task automatic step();
        bit [1:3] nfl; bit nerr; int act;
        @(posedge clk);
        model_eval(nfl, nerr, act);
        if (act == 1) m_q.push_back(m_fl);
        if (act == 2) void'(m_q.pop_back());
        m_fl  = nfl;
        m_err = nerr;
        #1;
        idle();
    endtask

    task automatic apply_reset();
        rst = 1'b1;
        idle();
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        m_fl = 3'b000; m_q.delete(); m_err = 1'b0;
    endtask

    task automatic test_reset();
        apply_reset();
        checks++;
        if ({z_o, n_o, c_o, depth_o, full_o, empty_o, err_o} !== {3'b000, 3'd0, 1'b0, 1'b1, 1'b0}) begin
            errors++;
            $display("FAIL reset_state: got flags=%b depth=%0d full=%b empty=%b err=%b, expected 000/0/0/1/0",
                     {z_o, n_o, c_o}, depth_o, full_o, empty_o, err_o);
        end
    endtask

    task automatic test_async_reset();
        apply_reset();
        alu_we = 1; {z_in, n_in, c_in} = 3'b111; step();
        save = 1; step();
        save = 1; step();
        checks++;
        if (depth_o !== 3'd2) begin
            errors++; $display("FAIL async_pre_depth: got %0d expected 2", depth_o);
        end
        #2 rst = 1'b1;
        #1;
        checks++;
        if ({z_o, n_o, c_o, depth_o, empty_o} !== {3'b000, 3'd0, 1'b1}) begin
            errors++;
            $display("FAIL async_reset: got flags=%b depth=%0d empty=%b expected 000/0/1",
                     {z_o, n_o, c_o}, depth_o, empty_o);
        end
        #1 rst = 1'b0;
        m_fl = 3'b000; m_q.delete(); m_err = 1'b0;
    endtask

    task automatic test_jump();
        apply_reset();
        alu_we = 1; {z_in, n_in, c_in} = 3'b101; step();
        jc = 2'b01;
        #1;
        checks++;
        if (jt_o !== 1'b1) begin
            errors++; $display("FAIL jz_taken: got %b expected 1", jt_o);
        end
        step();
        checks++;
        if ({z_o, n_o, c_o} !== 3'b001) begin
            errors++; $display("FAIL jz_clear: got %b expected 001", {z_o, n_o, c_o});
        end
    endtask

    task automatic test_save_restore();
        apply_reset();
        alu_we = 1; {z_in, n_in, c_in} = 3'b011; step();
        save = 1; alu_we = 1; {z_in, n_in, c_in} = 3'b100; step();
        checks++;
        if ({z_o, n_o, c_o, depth_o} !== {3'b100, 3'd1}) begin
            errors++; $display("FAIL save: got flags=%b depth=%0d expected 100/1", {z_o, n_o, c_o}, depth_o);
        end
        restore = 1; step();
        checks++;
        if ({z_o, n_o, c_o, depth_o, err_o} !== {3'b011, 3'd0, 1'b0}) begin
            errors++; $display("FAIL restore: got flags=%b depth=%0d err=%b expected 011/0/0",
                               {z_o, n_o, c_o}, depth_o, err_o);
        end
    endtask

    task automatic test_overflow();
        apply_reset();
        for (int i = 1; i <= 5; i++) begin
            save = 1; step();
            checks++;
            if (depth_o !== DW'((i > SD) ? SD : i) || full_o !== (i >= SD) || err_o !== (i == 5)) begin
                errors++;
                $display("FAIL overflow_%0d: got depth=%0d full=%b err=%b expected %0d/%b/%b", i,
                         depth_o, full_o, err_o, (i > SD) ? SD : i, (i >= SD), (i == 5));
            end
        end
        step();
        checks++;
        if (err_o !== 1'b0) begin
            errors++; $display("FAIL overflow_pulse_len: got err=%b expected 0", err_o);
        end
        apply_reset();
        alu_we = 1; {z_in, n_in, c_in} = 3'b110; step();
        restore = 1; step();
        checks++;
        if ({z_o, n_o, c_o, depth_o, err_o} !== {3'b110, 3'd0, 1'b1}) begin
            errors++; $display("FAIL underflow: got flags=%b depth=%0d err=%b expected 110/0/1",
                               {z_o, n_o, c_o}, depth_o, err_o);
        end
    endtask

    task automatic test_stall();
        apply_reset();
        alu_we = 1; {z_in, n_in, c_in} = 3'b001; step();
        save = 1; step();
        stall = 1; alu_we = 1; {z_in, n_in, c_in} = 3'b110; setc = 1; save = 1; jc = 2'b11;
        #1;
        checks++;
        if (jt_o !== 1'b1) begin
            errors++; $display("FAIL stall_jt: got %b expected 1", jt_o);
        end
        step();
        checks++;
        if ({z_o, n_o, c_o, depth_o, err_o} !== {3'b001, 3'd1, 1'b0}) begin
            errors++; $display("FAIL stall_hold: got flags=%b depth=%0d err=%b expected 001/1/0",
                               {z_o, n_o, c_o}, depth_o, err_o);
        end
    endtask

    task automatic test_priority();
        apply_reset();
        alu_we = 1; {z_in, n_in, c_in} = 3'b011; step();
        setc = 1; clrc = 1; jc = 2'b11; step();
        checks++;
        if ({z_o, n_o, c_o} !== 3'b010) begin
            errors++; $display("FAIL setc_vs_jc: got %b expected 010", {z_o, n_o, c_o});
        end
        setc = 1; step();
        save = 1; alu_we = 1; {z_in, n_in, c_in} = 3'b100; step();
        save = 1; restore = 1; step();
        checks++;
        if ({z_o, n_o, c_o, depth_o, err_o} !== {3'b011, 3'd0, 1'b1}) begin
            errors++; $display("FAIL save_restore_both: got flags=%b depth=%0d err=%b expected 011/0/1",
                               {z_o, n_o, c_o}, depth_o, err_o);
        end
    endtask

    task automatic test_random();
        bit [1:3] exp_fl; bit nerr; int act; bit exp_jt;
        apply_reset();
        for (int n = 0; n < 600; n++) begin
            stall   = ($urandom_range(0, 7) == 0);
            alu_we  = $urandom_range(0, 1);
            {z_in, n_in, c_in} = 3'($urandom_range(0, 7));
            setc    = ($urandom_range(0, 5) == 0);
            clrc    = ($urandom_range(0, 5) == 0);
            jc      = 2'($urandom_range(0, 3));
            save    = ($urandom_range(0, 3) == 0);
            restore = ($urandom_range(0, 4) == 0);
            #3;
            exp_fl = m_fl;
`ifdef FLAG_REGISTER_BYPASS_EN
            if (alu_we && !stall) model_eval(exp_fl, nerr, act);
`endif
            exp_jt = (jc != 2'd0) ? m_fl[jc] : 1'b0;
            checks++;
            if ({z_o, n_o, c_o} !== exp_fl || jt_o !== exp_jt || depth_o !== DW'(m_q.size()) ||
                full_o !== (m_q.size() == SD) || empty_o !== (m_q.size() == 0) ||
                err_o !== (m_err && !stall)) begin
                errors++;
                $display("FAIL random_%0d: got fl=%b jt=%b d=%0d f=%b e=%b err=%b expected fl=%b jt=%b d=%0d err=%b",
                         n, {z_o, n_o, c_o}, jt_o, depth_o, full_o, empty_o, err_o,
                         exp_fl, exp_jt, m_q.size(), (m_err && !stall));
            end
            step();
        end
    endtask

    initial begin
        rst = 1'b1;
        idle();
        test_reset();
        test_jump();
        test_save_restore();
        test_overflow();
        test_stall();
        test_priority();
        test_async_reset();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
